instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the LEGv8 CPU, the producer side of the decode interface. It owns the PC, issues 64-bit word-aligned requests to instruction memory, and buffers returned 32-bit instructions with their addresses. It presents each instruction to decode over a valid/ready handshake. It consumes decode's branch redirect (`PCSrc`, `BranchAddress`) to flush and refetch.

## Interface
- `RESET_PC`, default 64'h0: PC loaded at reset. Must be word-aligned.
- `BUF_DEPTH`, default 2: depth of the fetch buffer in entries. Any power of two of 2 or more.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out 64: request address; bits [1:0] always 0.
- `imem_rsp_valid` in 1: response valid. Responses are in order, at least 1 cycle after acceptance, and cannot be stalled.
- `imem_rsp_data` in 32: fetched instruction word.
- `Instruction` out 32: instruction at the buffer head.
- `Address` out 64: PC of `Instruction`.
- `if_valid` out 1: the buffer head is valid.
- `id_ready` in 1: decode consumes the head this cycle.
- `PCSrc` in 1: redirect pulse from decode/execute.
- `BranchAddress` in 64: redirect target; bits [1:0] are ignored and forced to 0.

## Operation
- **State machine.**
  - IDLE: the reset state. Always moves to FETCH on the next cycle.
  - FETCH: no request outstanding.
  - WAIT: one request outstanding, response will be kept.
  - DROP: one request outstanding, response will be discarded.
- **Issue rule.**
  - `imem_req_valid` = (state==FETCH) && !PCSrc && (count < BUF_DEPTH).
  - At most one request is outstanding, so a buffered entry plus the outstanding request never exceed BUF_DEPTH.
- **Request accepted** (valid && ready): go FETCH→WAIT and latch `req_pc` = pc. The PC is not advanced on acceptance. It advances on response; see below.
- **Response in WAIT:**
  - push {req_pc, imem_rsp_data} into the buffer;
  - pc ← req_pc + 4, modulo 2^64, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0;
  - WAIT→FETCH.
- **Response in DROP:** discard the data, no push, pc unchanged, DROP→FETCH.
- **Redirect** (PCSrc=1), highest priority in its cycle:
  - flush the buffer (count←0);
  - pc ← {BranchAddress[63:2], 2'b00};
  - no request is issued that cycle;
  - FETCH stays FETCH;
  - WAIT→DROP, unless `imem_rsp_valid` is high the same cycle. In that case the response is dropped and the state goes to FETCH.
  - DROP stays DROP, unless a response arrives the same cycle. In that case the state goes to FETCH.
- **Pop:** `if_valid && id_ready` removes the head. Push and pop in the same cycle leave count unchanged. A pop in a redirect cycle is ignored because the flush wins.
- **Outputs when empty:** `if_valid`=0, and `Instruction`/`Address` hold their last value. Decode must ignore them.
- **Unexpected response:** `imem_rsp_valid` in FETCH or IDLE is a protocol error. It is ignored; no push.

## Timing
- **Reset values:** `imem_req_valid`=0, `imem_req_addr`=RESET_PC, `if_valid`=0, `Instruction`=32'h0, `Address`=64'h0, count=0, state=IDLE.
- **First request:** `imem_req_valid` first rises 1 cycle after the cycle in which `rst_n` is sampled high.
- **Buffer latency:** a response in cycle N makes `if_valid`=1 with that entry in cycle N+1. There is no combinational path from response to output.
- **Next request after a response:** the response in cycle N moves the state to FETCH at N+1, so the next request may be issued in N+1.
- **Peak throughput:** one instruction per (memory latency + 1) cycles.
- **Redirect timing:** PCSrc in cycle N gives `if_valid`=0 in N+1 and a request to BranchAddress in N+1, provided no request is outstanding at N+1.
- **Combinational dependencies:** `imem_req_valid` depends combinationally on `PCSrc`. No other output depends combinationally on an input.
- **Reset mid-operation:** `rst_n`=0 in any state restores all reset values on the next edge. Any outstanding response arriving after reset is treated as unexpected and ignored.

## Structure
- **Shared package `cpu_pkg`:**
  - `INSTR_W`=32, `ADDR_W`=64, `PC_INC`=64'd4;
  - `fetch_state_t` enum {IDLE, FETCH, WAIT, DROP};
  - packed struct `fetch_entry_t` {addr[63:0], instr[31:0]}.
- **Sub-module `fetch_buffer`:** parameterised synchronous FIFO of `fetch_entry_t`.
  - Ports: push, pop, flush, head, count.
  - Flush has priority over push and pop.
  - Head registered.
- **Top level:** holds the state machine, the PC, `req_pc` and the issue logic.

## Test plan
- **Reset and sequential fetch.** RESET_PC=64'h100, memory latency 1, `id_ready`=1. Expect:
  - requests to 0x100, 0x104, 0x108;
  - `Address` sequence 0x100, 0x104, 0x108 with the matching `Instruction` words;
  - exactly one outstanding request at any time.
- **Backpressure.** Hold `id_ready`=0 with BUF_DEPTH=2. Expect:
  - `imem_req_valid` stays 0 once count=2;
  - release `id_ready`: entries drain in order, then fetching resumes at 0x108.
- **Redirect with an outstanding request.** Pulse PCSrc with BranchAddress=64'h2003 while in WAIT; the response arrives 2 cycles later. Expect:
  - that response is discarded;
  - the next request is to 0x2000;
  - the first `Address` after redirect is 0x2000.
- **Redirect coincident with a response and a pop.** Expect:
  - buffer empty next cycle;
  - response not pushed;
  - state FETCH;
  - request to the target issued next cycle.
- **PC wrap.** RESET_PC=64'hFFFF_FFFF_FFFF_FFFC. Expect the second request to go to 0x0.
- **Mid-stream reset.** Assert `rst_n`=0 in WAIT, then give a response during reset and one after reset. Expect:
  - all outputs at reset values;
  - the stray response ignored;
  - fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared LEGv8 CPU definitions: datapath widths, fetch FSM states and the
// buffered fetch entry (instruction plus the PC it was fetched from).
package cpu_pkg;

   localparam int          INSTR_W = 32;
   localparam int          ADDR_W  = 64;
   localparam logic [63:0] PC_INC  = 64'd4;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WAIT,
      DROP
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-side bus bundle: instruction memory request/response, decode
// valid/ready handshake and the branch redirect coming back from decode.
interface instruction_fetch_if;
   import cpu_pkg::*;

   logic               imem_req_valid;
   logic               imem_req_ready;
   logic [ADDR_W-1:0]  imem_req_addr;
   logic               imem_rsp_valid;
   logic [INSTR_W-1:0] imem_rsp_data;
   logic [INSTR_W-1:0] Instruction;
   logic [ADDR_W-1:0]  Address;
   logic               if_valid;
   logic               id_ready;
   logic               PCSrc;
   logic [ADDR_W-1:0]  BranchAddress;

   modport master (
      output imem_req_valid, imem_req_addr, Instruction, Address, if_valid,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready, PCSrc, BranchAddress
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, Instruction, Address, if_valid,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready, PCSrc, BranchAddress
   );

endinterface

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetch entries with a registered head; flush beats
// push and pop in the same cycle.
module fetch_buffer
   import cpu_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  fetch_entry_t       push_data,
   input  logic               pop,
   input  logic               flush,
   output fetch_entry_t       head,
   output logic [CNT_W-1:0]   count
);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_next;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !flush;
   assign do_pop  = pop && (count != '0) && !flush;
   assign rd_next = rd_ptr + 1'b1;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_next;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
         // Head follows the next live entry; it holds its value when the buffer empties.
         if (do_pop) begin
            if (count > CNT_W'(1)) head <= mem[rd_next];
            else if (do_push)      head <= push_data;
         end else if (count == '0 && do_push) begin
            head <= push_data;
         end
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// LEGv8 fetch stage: owns the PC, keeps one instruction-memory request in
// flight and feeds decode from a small fetch buffer, flushing on redirect.
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC  = 64'h0,
   parameter int                BUF_DEPTH = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   instruction_fetch_if.master bus
);

   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] req_pc;
   logic [CNT_W-1:0]  count;
   fetch_entry_t      head;
   fetch_entry_t      push_data;
   logic              req_fire;
   logic              rsp_keep;
   logic              pop;

   assign bus.imem_req_valid = (state == FETCH) && !bus.PCSrc && (count < CNT_W'(BUF_DEPTH));
   assign bus.imem_req_addr  = pc;
   assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
   assign rsp_keep           = (state == WAIT) && bus.imem_rsp_valid && !bus.PCSrc;
   assign pop                = bus.if_valid && bus.id_ready;
   assign push_data          = '{addr: req_pc, instr: bus.imem_rsp_data};

   assign bus.if_valid    = (count != '0);
   assign bus.Instruction = head.instr;
   assign bus.Address     = head.addr;

   // The PC only advances when a kept response returns, so a dropped fetch
   // never skips an instruction.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         pc    <= RESET_PC;
      end else if (bus.PCSrc) begin
         pc <= word_align(bus.BranchAddress);
         case (state)
            IDLE:       state <= FETCH;
            FETCH:      state <= FETCH;
            WAIT, DROP: state <= bus.imem_rsp_valid ? FETCH : DROP;
            default:    state <= IDLE;
         endcase
      end else begin
         case (state)
            IDLE: state <= FETCH;
            FETCH: begin
               if (req_fire) begin
                  state  <= WAIT;
                  req_pc <= pc;
               end
            end
            WAIT: begin
               if (bus.imem_rsp_valid) begin
                  state <= FETCH;
                  pc    <= req_pc + PC_INC;
               end
            end
            DROP: if (bus.imem_rsp_valid) state <= FETCH;
            default: state <= IDLE;
         endcase
      end
   end

   fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rsp_keep),
      .push_data (push_data),
      .pop       (pop),
      .flush     (bus.PCSrc),
      .head      (head),
      .count     (count)
   );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected requests and decode
// outputs are queued by the directed sequences and popped by monitors.
module tb_instruction_fetch;
   import cpu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic rst_nb;

   instruction_fetch_if ifa ();
   instruction_fetch_if ifb ();

   instruction_fetch #(.RESET_PC(64'h100), .BUF_DEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa.master)
   );

   instruction_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .BUF_DEPTH(2)) dut_wrap (
      .clk   (clk),
      .rst_n (rst_nb),
      .bus   (ifb.master)
   );

   int tests = 0;
   int fails = 0;

   logic [63:0]  req_q [$];
   fetch_entry_t out_q [$];
   logic [63:0]  bq [$];
   fetch_entry_t bo [$];

   int          lat = 1;
   bit          pend = 1'b0;
   int          pend_cnt = 0;
   logic [63:0] pend_addr = '0;
   int          acc = 0;
   bit          inj = 1'b0;

   bit          pendb = 1'b0;
   logic [63:0] addrb = '0;
   int          accb = 0;

   function automatic logic [31:0] word_of(input logic [63:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   function automatic fetch_entry_t ent(input logic [63:0] a);
      fetch_entry_t r;
      r.addr  = a;
      r.instr = word_of(a);
      return r;
   endfunction

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_acc(input int target, input string name);
      int n = 0;
      while (acc < target && n < 100) begin
         step();
         n++;
      end
      tests++;
      if (acc < target) begin
         fails++;
         $display("FAIL %s: timeout with %0d requests, expected %0d", name, acc, target);
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((out_q.size() != 0 || req_q.size() != 0) && n < 100) begin
         step();
         n++;
      end
      tests++;
      if (out_q.size() != 0 || req_q.size() != 0) begin
         fails++;
         $display("FAIL %s: timeout, %0d outputs and %0d requests still expected", name, out_q.size(), req_q.size());
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ifa.imem_req_ready = 1'b0;
      ifa.PCSrc = 1'b0;
      ifa.id_ready = 1'b1;
      repeat (3) step();
      rst_n = 1'b1;
   endtask

   // Memory model for the main DUT: fixed latency, one stray-response injector,
   // and request checking against the expected request queue.
   initial begin
      ifa.imem_rsp_valid = 1'b0;
      ifa.imem_rsp_data  = '0;
      forever begin
         @(posedge clk);
         #2;
         ifa.imem_rsp_valid = 1'b0;
         if (pend) begin
            if (pend_cnt <= 1) begin
               ifa.imem_rsp_valid = 1'b1;
               ifa.imem_rsp_data  = word_of(pend_addr);
               pend = 1'b0;
            end else begin
               pend_cnt--;
            end
         end
         if (inj) begin
            ifa.imem_rsp_valid = 1'b1;
            ifa.imem_rsp_data  = 32'hBAD0_0000;
            inj = 1'b0;
         end
         @(negedge clk);
         if (ifa.imem_req_valid && ifa.imem_req_ready) begin
            check64("one_outstanding", 64'(pend), 64'd0);
            if (req_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_req: got %h expected none", ifa.imem_req_addr);
            end else begin
               check64("req_addr", ifa.imem_req_addr, req_q.pop_front());
            end
            pend      = 1'b1;
            pend_cnt  = lat;
            pend_addr = ifa.imem_req_addr;
            acc++;
         end
      end
   end

   // Decode-side monitor for the main DUT; a pop in a redirect cycle is flushed.
   initial begin
      fetch_entry_t e;
      forever begin
         @(negedge clk);
         if (ifa.if_valid && ifa.id_ready && !ifa.PCSrc) begin
            if (out_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_out: got %h/%h expected none", ifa.Address, ifa.Instruction);
            end else begin
               e = out_q.pop_front();
               check64("out_addr", ifa.Address, e.addr);
               check64("out_instr", 64'(ifa.Instruction), 64'(e.instr));
            end
         end
      end
   end

   // Latency-1 memory and monitor for the wrap-around DUT.
   initial begin
      fetch_entry_t e;
      ifb.imem_rsp_valid = 1'b0;
      ifb.imem_rsp_data  = '0;
      forever begin
         @(posedge clk);
         #2;
         ifb.imem_rsp_valid = pendb;
         ifb.imem_rsp_data  = word_of(addrb);
         pendb = 1'b0;
         @(negedge clk);
         if (ifb.imem_req_valid && ifb.imem_req_ready) begin
            if (bq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL wrap_unexpected_req: got %h expected none", ifb.imem_req_addr);
            end else begin
               check64("wrap_req_addr", ifb.imem_req_addr, bq.pop_front());
            end
            pendb = 1'b1;
            addrb = ifb.imem_req_addr;
            accb++;
         end
         if (ifb.if_valid && ifb.id_ready) begin
            if (bo.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL wrap_unexpected_out: got %h expected none", ifb.Address);
            end else begin
               e = bo.pop_front();
               check64("wrap_out_addr", ifb.Address, e.addr);
               check64("wrap_out_instr", 64'(ifb.Instruction), 64'(e.instr));
            end
         end
      end
   end

   initial begin
      int base;
      int n;
      rst_n  = 1'b0;
      rst_nb = 1'b0;
      ifa.imem_req_ready = 1'b0;
      ifa.id_ready       = 1'b1;
      ifa.PCSrc          = 1'b0;
      ifa.BranchAddress  = '0;
      ifb.imem_req_ready = 1'b1;
      ifb.id_ready       = 1'b1;
      ifb.PCSrc          = 1'b0;
      ifb.BranchAddress  = '0;

      // Reset values and first-request timing
      repeat (3) step();
      @(negedge clk);
      check64("rst_req_valid", 64'(ifa.imem_req_valid), 64'd0);
      check64("rst_req_addr", ifa.imem_req_addr, 64'h100);
      check64("rst_if_valid", 64'(ifa.if_valid), 64'd0);
      check64("rst_instruction", 64'(ifa.Instruction), 64'd0);
      check64("rst_address", ifa.Address, 64'd0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check64("first_req_early", 64'(ifa.imem_req_valid), 64'd0);
      step();
      @(negedge clk);
      check64("first_req_rise", 64'(ifa.imem_req_valid), 64'd1);
      check64("first_req_addr", ifa.imem_req_addr, 64'h100);
      step();

      // Sequential fetch, latency 1
      base = acc;
      req_q.push_back(64'h100); req_q.push_back(64'h104); req_q.push_back(64'h108);
      out_q.push_back(ent(64'h100)); out_q.push_back(ent(64'h104)); out_q.push_back(ent(64'h108));
      ifa.imem_req_ready = 1'b1;
      wait_acc(base + 3, "seq_reqs");
      ifa.imem_req_ready = 1'b0;
      wait_drain("seq_drain");

      // Backpressure with a full buffer
      do_reset();
      ifa.id_ready = 1'b0;
      base = acc;
      req_q.push_back(64'h100); req_q.push_back(64'h104); req_q.push_back(64'h108);
      out_q.push_back(ent(64'h100)); out_q.push_back(ent(64'h104)); out_q.push_back(ent(64'h108));
      ifa.imem_req_ready = 1'b1;
      repeat (10) step();
      @(negedge clk);
      check64("bp_req_count", 64'(acc), 64'(base + 2));
      check64("bp_stall", 64'(ifa.imem_req_valid), 64'd0);
      check64("bp_head", ifa.Address, 64'h100);
      step();
      ifa.id_ready = 1'b1;
      wait_acc(base + 3, "bp_resume");
      ifa.imem_req_ready = 1'b0;
      wait_drain("bp_drain");

      // Redirect gating the request, then redirect while a request is outstanding
      lat = 3;
      do_reset();
      step();
      ifa.PCSrc = 1'b1;
      ifa.BranchAddress = 64'h100;
      @(negedge clk);
      check64("redirect_blocks_req", 64'(ifa.imem_req_valid), 64'd0);
      step();
      ifa.PCSrc = 1'b0;
      @(negedge clk);
      check64("redirect_req_next", 64'(ifa.imem_req_valid), 64'd1);
      check64("redirect_req_addr", ifa.imem_req_addr, 64'h100);
      step();
      base = acc;
      req_q.push_back(64'h100); req_q.push_back(64'h2000);
      out_q.push_back(ent(64'h2000));
      ifa.imem_req_ready = 1'b1;
      wait_acc(base + 1, "drop_first_req");
      ifa.PCSrc = 1'b1;
      ifa.BranchAddress = 64'h2003;
      step();
      ifa.PCSrc = 1'b0;
      wait_acc(base + 2, "drop_target_req");
      ifa.imem_req_ready = 1'b0;
      wait_drain("drop_drain");

      // Redirect coincident with a response and a pop
      lat = 2;
      do_reset();
      ifa.id_ready = 1'b0;
      base = acc;
      req_q.push_back(64'h100); req_q.push_back(64'h104); req_q.push_back(64'h3000);
      out_q.push_back(ent(64'h3000));
      ifa.imem_req_ready = 1'b1;
      wait_acc(base + 2, "coinc_reqs");
      step();
      ifa.PCSrc = 1'b1;
      ifa.BranchAddress = 64'h3000;
      ifa.id_ready = 1'b1;
      @(negedge clk);
      check64("coinc_head_before", ifa.Address, 64'h100);
      step();
      ifa.PCSrc = 1'b0;
      @(negedge clk);
      check64("coinc_flush", 64'(ifa.if_valid), 64'd0);
      check64("coinc_req", 64'(ifa.imem_req_valid), 64'd1);
      check64("coinc_req_addr", ifa.imem_req_addr, 64'h3000);
      step();
      wait_acc(base + 3, "coinc_target_req");
      ifa.imem_req_ready = 1'b0;
      wait_drain("coinc_drain");

      // Reset while a request is outstanding, with stray responses around it
      lat = 3;
      do_reset();
      base = acc;
      req_q.push_back(64'h100); req_q.push_back(64'h104);
      out_q.push_back(ent(64'h100));
      ifa.imem_req_ready = 1'b1;
      wait_acc(base + 2, "mid_reqs");
      rst_n = 1'b0;
      ifa.imem_req_ready = 1'b0;
      step();
      @(negedge clk);
      check64("mid_rst_req_valid", 64'(ifa.imem_req_valid), 64'd0);
      check64("mid_rst_req_addr", ifa.imem_req_addr, 64'h100);
      check64("mid_rst_if_valid", 64'(ifa.if_valid), 64'd0);
      check64("mid_rst_instruction", 64'(ifa.Instruction), 64'd0);
      check64("mid_rst_address", ifa.Address, 64'd0);
      step();
      step();
      rst_n = 1'b1;
      inj = 1'b1;
      @(negedge clk);
      check64("mid_idle_no_req", 64'(ifa.imem_req_valid), 64'd0);
      step();
      inj = 1'b1;
      @(negedge clk);
      check64("mid_restart_valid", 64'(ifa.imem_req_valid), 64'd1);
      check64("mid_restart_addr", ifa.imem_req_addr, 64'h100);
      step();
      @(negedge clk);
      check64("mid_stray_ignored", 64'(ifa.if_valid), 64'd0);
      step();
      req_q.push_back(64'h100);
      out_q.push_back(ent(64'h100));
      ifa.imem_req_ready = 1'b1;
      wait_acc(base + 3, "mid_restart_req");
      ifa.imem_req_ready = 1'b0;
      wait_drain("mid_drain");

      // PC wrap on the second DUT
      bq.push_back(64'hFFFF_FFFF_FFFF_FFFC); bq.push_back(64'h0);
      bo.push_back(ent(64'hFFFF_FFFF_FFFF_FFFC)); bo.push_back(ent(64'h0));
      rst_nb = 1'b1;
      n = 0;
      while (accb < 2 && n < 50) begin
         step();
         n++;
      end
      ifb.imem_req_ready = 1'b0;
      check64("wrap_req_count", 64'(accb), 64'd2);
      n = 0;
      while (bo.size() != 0 && n < 50) begin
         step();
         n++;
      end
      check64("wrap_out_left", 64'(bo.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
